// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan controller.
//   SEG_BLANK_CODE : 5-bit code that blanks a digit (bit 4 set)
//   HEX_GLYPH      : active-high segment patterns for hex 0..F, bit0 = a .. bit6 = g
//   scan_state_e   : scan FSM states (blank dead-time / drive)
package seven_seg_pkg;

    localparam logic [4:0] SEG_BLANK_CODE = 5'h10;

    // Index 0 first: 0 1 2 3 4 5 6 7 8 9 A b C d E F
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg_hex_glyph.sv
// Combinational glyph decoder.
//   code_i : [4]=1 blank, else [3:0] hex value
//   seg_o  : active-high segments a..g (bit0 = a); pin polarity is applied by the caller
module seg_hex_glyph
    import seven_seg_pkg::*;
(
    input  logic [4:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h00;
        if (!code_i[4]) begin
            seg_o = HEX_GLYPH[code_i[3:0]];
        end
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-segment seven-segment display.
//   CLK, RST_N          : clock and asynchronous active-low reset
//   wr_valid/wr_ready   : write handshake; wr_digit/wr_code/wr_dp land in shadow registers
//   brightness          : 4-bit PWM duty (15 = always on within the drive window)
//   SEG, DP, DIGIT_EN   : registered display pins (polarity set by parameters)
//   scan_idx            : digit slot currently being scanned
//   frame_tick          : high in the cycle where shadow registers are copied to active
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int  NUM_DIGITS   = 4,
    parameter int  CLK_HZ       = 100000000,
    parameter int  SCAN_HZ      = 1000,
    parameter int  BLANK_CYCLES = 200,
    parameter bit  SEG_ACT_LOW  = 1'b0,
    parameter bit  DIG_ACT_LOW  = 1'b1,
    localparam int DW           = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DW-1:0]         wr_digit,
    input  logic [4:0]            wr_code,
    input  logic                  wr_dp,
    input  logic [3:0]            brightness,
    output logic [6:0]            SEG,
    output logic                  DP,
    output logic [NUM_DIGITS-1:0] DIGIT_EN,
    output logic [DW-1:0]         scan_idx,
    output logic                  frame_tick
);

    localparam int DWELL = CLK_HZ / SCAN_HZ;
    localparam int CW    = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CW-1:0]         LAST_CNT  = CW'(DWELL - 1);
    localparam logic [CW-1:0]         BLANK_CNT = CW'(BLANK_CYCLES);
    localparam logic [DW-1:0]         LAST_DIG  = DW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF   = {7{SEG_ACT_LOW}};
    localparam logic                  DP_OFF    = SEG_ACT_LOW;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF   = {NUM_DIGITS{DIG_ACT_LOW}};

    // Scan state
    logic [CW-1:0]         cnt_q, cnt_d;
    scan_state_e           state_q, state_d;
    logic [DW-1:0]         scan_q, scan_d;
    logic [3:0]            phase_q, phase_d;
    logic                  commit_q, commit_d;
    logic                  ready_q, ready_d;

    // Pin registers
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;

    // Register files
    logic [4:0]            shadow_code_q [NUM_DIGITS];
    logic                  shadow_dp_q   [NUM_DIGITS];
    logic [4:0]            active_code_q [NUM_DIGITS];
    logic                  active_dp_q   [NUM_DIGITS];

    logic                  wr_fire;
    logic                  cnt_wrap;
    logic                  drive_lit;
    logic [4:0]            cur_code;
    logic                  cur_dp;
    logic [6:0]            cur_glyph;
    logic [NUM_DIGITS-1:0] scan_onehot;

    assign wr_fire  = wr_valid && ready_q;
    assign cur_code = active_code_q[scan_q];
    assign cur_dp   = active_dp_q[scan_q];

    seg_hex_glyph u_glyph (
        .code_i (cur_code),
        .seg_o  (cur_glyph)
    );

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_onehot
        assign scan_onehot[gi] = (scan_q == DW'(gi));
    end

    always_comb begin
        cnt_wrap = (cnt_q == LAST_CNT);
        cnt_d    = cnt_wrap ? '0 : cnt_q + CW'(1);

        scan_d = scan_q;
        if (cnt_wrap) begin
            scan_d = (scan_q == LAST_DIG) ? '0 : scan_q + DW'(1);
        end

        // The FSM state is a pure function of the slot count, registered so it
        // stays aligned with cnt_q.
        state_d = (cnt_d >= BLANK_CNT) ? ST_DRIVE : ST_BLANK;

        phase_d = phase_q;
        if (cnt_d == BLANK_CNT) begin
            phase_d = 4'd0;
        end else if (state_q == ST_DRIVE) begin
            phase_d = phase_q + 4'd1;
        end

        // Flag the upcoming commit cycle one cycle early so frame_tick and
        // wr_ready come straight from flops.
        commit_d = (cnt_d == LAST_CNT) && (scan_d == LAST_DIG);
        ready_d  = !commit_d;

        drive_lit = (brightness == 4'hF) || (phase_q < brightness);

        seg_d = SEG_OFF;
        dp_d  = DP_OFF;
        dig_d = DIG_OFF;
        if (state_q == ST_DRIVE) begin
            seg_d = cur_glyph ^ {7{SEG_ACT_LOW}};
            dp_d  = cur_dp ^ SEG_ACT_LOW;
            if (drive_lit) begin
                dig_d = scan_onehot ^ {NUM_DIGITS{DIG_ACT_LOW}};
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q    <= '0;
            state_q  <= ST_BLANK;
            scan_q   <= '0;
            phase_q  <= 4'd0;
            commit_q <= 1'b0;
            ready_q  <= 1'b0;
            seg_q    <= SEG_OFF;
            dp_q     <= DP_OFF;
            dig_q    <= DIG_OFF;
        end else begin
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            scan_q   <= scan_d;
            phase_q  <= phase_d;
            commit_q <= commit_d;
            ready_q  <= ready_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            dig_q    <= dig_d;
        end
    end

    // Per-digit shadow/active pair. Out-of-range wr_digit matches no entry and
    // is dropped. Writes and commits never coincide because wr_ready is low in
    // the commit cycle.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                shadow_code_q[gi] <= SEG_BLANK_CODE;
                shadow_dp_q[gi]   <= 1'b0;
                active_code_q[gi] <= SEG_BLANK_CODE;
                active_dp_q[gi]   <= 1'b0;
            end else begin
                if (wr_fire && (wr_digit == DW'(gi))) begin
                    shadow_code_q[gi] <= wr_code;
                    shadow_dp_q[gi]   <= wr_dp;
                end
                if (commit_q) begin
                    active_code_q[gi] <= shadow_code_q[gi];
                    active_dp_q[gi]   <= shadow_dp_q[gi];
                end
            end
        end
    end

    assign wr_ready   = ready_q;
    assign frame_tick = commit_q;
    assign scan_idx   = scan_q;
    assign SEG        = seg_q;
    assign DP         = dp_q;
    assign DIGIT_EN   = dig_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench: DWELL=10, BLANK=2. Main instance has 4 digits; a second
// 5-digit instance (3-bit wr_digit) exercises out-of-range write discard.
// k counts posedges since reset release; pins after edge k reflect scan time k-1.
module tb_seven_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] brightness;

    logic       wr_valid, wr_ready, wr_dp, dp, frame_tick;
    logic [1:0] wr_digit, scan_idx;
    logic [4:0] wr_code;
    logic [6:0] seg;
    logic [3:0] digit_en;

    logic       wr_valid5, wr_ready5, wr_dp5, dp5, frame_tick5;
    logic [2:0] wr_digit5, scan_idx5;
    logic [4:0] wr_code5;
    logic [6:0] seg5;
    logic [4:0] digit_en5;

    int k = 0;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(4), .CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYCLES(2),
        .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b1)
    ) u_dut (
        .CLK(clk), .RST_N(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_digit(wr_digit), .wr_code(wr_code), .wr_dp(wr_dp), .brightness(brightness),
        .SEG(seg), .DP(dp), .DIGIT_EN(digit_en), .scan_idx(scan_idx), .frame_tick(frame_tick)
    );

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(5), .CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYCLES(2),
        .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b1)
    ) u_dut5 (
        .CLK(clk), .RST_N(rst_n), .wr_valid(wr_valid5), .wr_ready(wr_ready5),
        .wr_digit(wr_digit5), .wr_code(wr_code5), .wr_dp(wr_dp5), .brightness(brightness),
        .SEG(seg5), .DP(dp5), .DIGIT_EN(digit_en5), .scan_idx(scan_idx5), .frame_tick(frame_tick5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s (k=%0d): observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    // Advance to the negedge following posedge number 'target'.
    task automatic go(input int target);
        while (k < target) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk);
    endtask

    initial begin
        brightness = 4'hF;
        wr_valid = 1'b0;  wr_digit = '0;  wr_code = '0;  wr_dp = 1'b0;
        wr_valid5 = 1'b0; wr_digit5 = '0; wr_code5 = '0; wr_dp5 = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_seg", 32'(seg), 32'h00);
        chk("rst_dp", 32'(dp), 32'h0);
        chk("rst_dig", 32'(digit_en), 32'hF);
        chk("rst_ready", 32'(wr_ready), 32'h0);
        chk("rst_tick", 32'(frame_tick), 32'h0);
        chk("rst_scan", 32'(scan_idx), 32'h0);

        rst_n = 1'b1;
        k = 0;
        go(1);
        chk("rel_ready", 32'(wr_ready), 32'h1);
        chk("rel_dig1", 32'(digit_en), 32'hF);
        go(2);
        chk("rel_dig2", 32'(digit_en), 32'hF);
        go(3);
        chk("first_drive_dig", 32'(digit_en), 32'hE);
        chk("first_drive_seg", 32'(seg), 32'h00);
        chk("first_drive_dp", 32'(dp), 32'h0);

        // Writes: digit2 <= 8 with dp; 5-digit instance gets digit 7 (discard) and digit 4
        wr_valid = 1'b1; wr_digit = 2'd2; wr_code = 5'h08; wr_dp = 1'b1;
        wr_valid5 = 1'b1; wr_digit5 = 3'd7; wr_code5 = 5'h08; wr_dp5 = 1'b1;
        go(4);
        wr_valid = 1'b0;
        wr_digit5 = 3'd4; wr_code5 = 5'h01; wr_dp5 = 1'b0;
        go(5);
        wr_valid5 = 1'b0;
        // Back-to-back writes to digit0: last (2) wins
        wr_valid = 1'b1; wr_digit = 2'd0; wr_code = 5'h01; wr_dp = 1'b0;
        go(6);
        wr_code = 5'h02;
        go(7);
        wr_valid = 1'b0;

        go(25);
        chk("pre_commit_dig", 32'(digit_en), 32'hB);
        chk("pre_commit_seg", 32'(seg), 32'h00);
        chk("pre_commit_dp", 32'(dp), 32'h0);
        chk("scan_idx_slot2", 32'(scan_idx), 32'h2);

        go(38);
        chk("tick_before", 32'(frame_tick), 32'h0);
        chk("ready_before", 32'(wr_ready), 32'h1);
        go(39);
        chk("tick_commit", 32'(frame_tick), 32'h1);
        chk("ready_commit", 32'(wr_ready), 32'h0);
        chk("tick5_not_yet", 32'(frame_tick5), 32'h0);
        go(40);
        chk("tick_after", 32'(frame_tick), 32'h0);
        chk("ready_after", 32'(wr_ready), 32'h1);
        chk("slot3_tail_dig", 32'(digit_en), 32'h7);

        go(43);
        chk("f1_d0_dig", 32'(digit_en), 32'hE);
        chk("f1_d0_seg_lastwin", 32'(seg), 32'h5B);
        chk("u5_d4_before_seg", 32'(seg5), 32'h00);
        chk("u5_d4_dig", 32'(digit_en5), 32'h0F);
        go(49);
        chk("u5_tick", 32'(frame_tick5), 32'h1);
        go(53);
        chk("f1_d1_dig", 32'(digit_en), 32'hD);
        chk("f1_d1_seg", 32'(seg), 32'h00);
        go(61);
        chk("f1_d2_blank_dig", 32'(digit_en), 32'hF);
        chk("f1_d2_blank_seg", 32'(seg), 32'h00);
        go(63);
        chk("f1_d2_dig", 32'(digit_en), 32'hB);
        chk("f1_d2_seg", 32'(seg), 32'h7F);
        chk("f1_d2_dp", 32'(dp), 32'h1);
        go(70);
        chk("f1_d2_last_dig", 32'(digit_en), 32'hB);
        chk("f1_d2_last_seg", 32'(seg), 32'h7F);
        go(71);
        chk("f1_d3_blank_dig", 32'(digit_en), 32'hF);
        chk("f1_d3_blank_seg", 32'(seg), 32'h00);
        chk("f1_d3_blank_dp", 32'(dp), 32'h0);
        go(73);
        chk("f1_d3_dig", 32'(digit_en), 32'h7);
        chk("u5_d2_seg", 32'(seg5), 32'h00);
        chk("u5_d2_dig", 32'(digit_en5), 32'h1B);
        go(79);
        chk("tick_frame2", 32'(frame_tick), 32'h1);

        // PWM: brightness 4 -> enable for phases 0..3 of the 8-cycle window
        go(81);
        brightness = 4'd4;
        go(83);
        chk("pwm_ph0_dig", 32'(digit_en), 32'hE);
        chk("pwm_ph0_seg", 32'(seg), 32'h5B);
        chk("u5_d3_seg_discard", 32'(seg5), 32'h00);
        chk("u5_d3_dig", 32'(digit_en5), 32'h17);
        go(86);
        chk("pwm_ph3_dig", 32'(digit_en), 32'hE);
        go(87);
        chk("pwm_ph4_dig", 32'(digit_en), 32'hF);
        go(90);
        chk("pwm_ph7_dig", 32'(digit_en), 32'hF);
        go(93);
        chk("u5_d4_seg", 32'(seg5), 32'h06);
        chk("u5_d4_dig_ph0", 32'(digit_en5), 32'h0F);
        chk("pwm_d1_ph0_dig", 32'(digit_en), 32'hD);
        go(106);
        chk("pwm_d2_ph3_dig", 32'(digit_en), 32'hB);
        go(107);
        chk("pwm_d2_ph4_dig", 32'(digit_en), 32'hF);
        chk("pwm_d2_ph4_seg", 32'(seg), 32'h7F);
        go(108);
        chk("pwm_d2_ph5_dp", 32'(dp), 32'h1);
        brightness = 4'hF;

        // Write held valid across the commit cycle
        go(118);
        chk("ready_118", 32'(wr_ready), 32'h1);
        go(119);
        chk("tick_119", 32'(frame_tick), 32'h1);
        chk("ready_119", 32'(wr_ready), 32'h0);
        wr_valid = 1'b1; wr_digit = 2'd1; wr_code = 5'h0A; wr_dp = 1'b0;
        go(120);
        chk("ready_120", 32'(wr_ready), 32'h1);
        chk("tick_120", 32'(frame_tick), 32'h0);
        go(121);
        wr_valid = 1'b0;
        go(135);
        chk("held_not_yet_dig", 32'(digit_en), 32'hD);
        chk("held_not_yet_seg", 32'(seg), 32'h00);
        go(175);
        chk("held_visible_dig", 32'(digit_en), 32'hD);
        chk("held_visible_seg", 32'(seg), 32'h77);

        // Reset mid-DRIVE of digit 3
        go(195);
        chk("mid_drive_dig", 32'(digit_en), 32'h7);
        chk("mid_drive_scan", 32'(scan_idx), 32'h3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_dig", 32'(digit_en), 32'hF);
        chk("async_rst_seg", 32'(seg), 32'h00);
        chk("async_rst_dp", 32'(dp), 32'h0);
        chk("async_rst_ready", 32'(wr_ready), 32'h0);
        chk("async_rst_scan", 32'(scan_idx), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        go(1);
        chk("rst2_ready", 32'(wr_ready), 32'h1);
        chk("rst2_scan", 32'(scan_idx), 32'h0);
        go(3);
        chk("rst2_d0_dig", 32'(digit_en), 32'hE);
        chk("rst2_d0_seg", 32'(seg), 32'h00);
        go(23);
        chk("rst2_d2_dig", 32'(digit_en), 32'hB);
        chk("rst2_d2_seg", 32'(seg), 32'h00);
        go(43);
        chk("rst2_f1_d0_seg", 32'(seg), 32'h00);
        go(63);
        chk("rst2_f1_d2_dig", 32'(digit_en), 32'hB);
        chk("rst2_f1_d2_seg", 32'(seg), 32'h00);
        chk("rst2_f1_d2_dp", 32'(dp), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
